// File: rtl/mc_path_collector.sv
// Collects per-core Monte Carlo path sums into holding slots, drains them round-robin onto a
// valid/ready stream and keeps batch totals. Optional PATH_SUMSQ_EN adds a sum-of-squares total.
module mc_path_collector #(
    parameter int unsigned NCORES    = 4,
    parameter int unsigned LOGT      = 9,
    parameter int unsigned NUM_PATHS = 1024,
    parameter int unsigned LOGP      = 10,
    localparam int unsigned ACC_W    = 18 + LOGT
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     iStart,
    input  logic [NCORES*ACC_W-1:0]  iAcc,
    input  logic [NCORES-1:0]        iDone,
    output logic                     oPathValid,
    input  logic                     iPathReady,
    output logic [ACC_W-1:0]         oPathSum,
    output logic [3:0]               oPathCore,
    output logic [ACC_W+LOGP-1:0]    oTotal,
    output logic [LOGP:0]            oCount,
    output logic                     oBatchDone,
`ifdef PATH_SUMSQ_EN
    output logic [2*ACC_W+LOGP-1:0]  oTotalSq,
`endif
    output logic                     oOverrun
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam int unsigned    TOT_W    = ACC_W + LOGP;
    localparam logic [LOGP:0]  NumPaths = (LOGP+1)'(NUM_PATHS);

    state_e             state_q, state_d;
    logic [NCORES-1:0]  done_d1_q;
    logic [NCORES-1:0]  full_q, full_d, grant_oh, drain_oh;
    logic [ACC_W-1:0]   slot_q [NCORES];
    logic [ACC_W-1:0]   slot_d [NCORES];
    logic               valid_q, valid_d;
    logic [ACC_W-1:0]   sum_q, sum_d, grant_val;
    logic [3:0]         core_q, core_d, last_q, last_d, grant_idx;
    logic [TOT_W-1:0]   total_q, total_d;
    logic [LOGP:0]      count_q, count_d;
    logic               overrun_q, overrun_d;
    logic               grant_found, hs, acc_en, last_path, load;

    // Round-robin: lowest full slot above the last grant, else wrap to the lowest full slot.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        grant_val   = '0;
        for (int k = 0; k < int'(NCORES); k++) begin
            if (!grant_found && full_q[k] && (4'(k) > last_q)) begin
                grant_found = 1'b1;
                grant_idx   = 4'(k);
                grant_oh[k] = 1'b1;
                grant_val   = slot_q[k];
            end
        end
        for (int k = 0; k < int'(NCORES); k++) begin
            if (!grant_found && full_q[k] && (4'(k) <= last_q)) begin
                grant_found = 1'b1;
                grant_idx   = 4'(k);
                grant_oh[k] = 1'b1;
                grant_val   = slot_q[k];
            end
        end
    end

    always_comb begin
        hs        = valid_q && iPathReady;
        acc_en    = hs && (state_q == StRun);
        last_path = acc_en && ((count_q + (LOGP+1)'(1)) == NumPaths);
        // No new word is loaded on the handshake that completes the batch.
        load      = (!valid_q || iPathReady) && (state_q == StRun) && !last_path
                    && grant_found && !iStart;
        drain_oh  = load ? grant_oh : '0;

        valid_d   = valid_q;
        sum_d     = sum_q;
        core_d    = core_q;
        last_d    = last_q;
        total_d   = total_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        full_d    = full_q;
        slot_d    = slot_q;

        if (hs) valid_d = 1'b0;
        if (load) begin
            valid_d = 1'b1;
            sum_d   = grant_val;
            core_d  = grant_idx;
            last_d  = grant_idx;
        end
        if (acc_en) begin
            total_d = total_q + TOT_W'(sum_q);
            count_d = count_q + (LOGP+1)'(1);
        end

        for (int k = 0; k < int'(NCORES); k++) begin
            full_d[k] = full_q[k] && !drain_oh[k];
            if (done_d1_q[k] && (state_q == StRun) && !iStart) begin
                if (full_d[k]) begin
                    overrun_d = 1'b1;
                end else begin
                    slot_d[k] = iAcc[k*ACC_W +: ACC_W];
                    full_d[k] = 1'b1;
                end
            end
        end

        if (iStart) begin
            valid_d = 1'b0;
            sum_d   = '0;
            core_d  = '0;
            last_d  = 4'(NCORES - 1);
            total_d = '0;
            count_d = '0;
            full_d  = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (iStart) begin
            state_d = StRun;
        end else if ((state_q == StRun) && last_path) begin
            state_d = StDone;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            done_d1_q <= '0;
            full_q    <= '0;
            valid_q   <= 1'b0;
            sum_q     <= '0;
            core_q    <= '0;
            last_q    <= 4'(NCORES - 1);
            total_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            for (int k = 0; k < int'(NCORES); k++) slot_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            done_d1_q <= iDone;
            full_q    <= full_d;
            valid_q   <= valid_d;
            sum_q     <= sum_d;
            core_q    <= core_d;
            last_q    <= last_d;
            total_q   <= total_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            for (int k = 0; k < int'(NCORES); k++) slot_q[k] <= slot_d[k];
        end
    end

`ifdef PATH_SUMSQ_EN
    logic [ACC_W-1:0]          sq_a_q;
    logic [2*ACC_W-1:0]        sq_p_q;
    logic                      sq_v1_q, sq_v2_q;
    logic [2*ACC_W+LOGP-1:0]   sq_tot_q;

    // Register, multiply, accumulate: the square total trails oTotal by two cycles.
    always_ff @(posedge CLK) begin
        if (RST || iStart) begin
            sq_a_q   <= '0;
            sq_p_q   <= '0;
            sq_v1_q  <= 1'b0;
            sq_v2_q  <= 1'b0;
            sq_tot_q <= '0;
        end else begin
            sq_v1_q <= acc_en;
            sq_a_q  <= sum_q;
            sq_v2_q <= sq_v1_q;
            sq_p_q  <= sq_a_q * sq_a_q;
            if (sq_v2_q) sq_tot_q <= sq_tot_q + (2*ACC_W+LOGP)'(sq_p_q);
        end
    end

    assign oTotalSq = sq_tot_q;
`endif

    assign oPathValid = valid_q;
    assign oPathSum   = sum_q;
    assign oPathCore  = core_q;
    assign oTotal     = total_q;
    assign oCount     = count_q;
    assign oBatchDone = (state_q == StDone);
    assign oOverrun   = overrun_q;

endmodule

// File: tb/tb_mc_path_collector.sv
// Self-checking bench for mc_path_collector (NCORES=4, NUM_PATHS=4): directed table, hand-written
// corner sequences and randomized batches scored against a transaction-level model.
module tb_mc_path_collector;

    localparam int unsigned NC = 4;
    localparam int unsigned AW = 27;
    localparam int unsigned TW = 37;

    logic            clk, rst, start, ready;
    logic [NC*AW-1:0] acc;
    logic [NC-1:0]   done;
    logic            valid, bdone, overrun;
    logic [AW-1:0]   psum;
    logic [3:0]      pcore;
    logic [TW-1:0]   total;
    logic [10:0]     count;
`ifdef PATH_SUMSQ_EN
    logic [63:0]     totsq;
`endif

    mc_path_collector #(
        .NCORES(NC), .LOGT(9), .NUM_PATHS(4), .LOGP(10)
    ) dut (
        .CLK(clk), .RST(rst), .iStart(start), .iAcc(acc), .iDone(done),
        .oPathValid(valid), .iPathReady(ready), .oPathSum(psum), .oPathCore(pcore),
        .oTotal(total), .oCount(count), .oBatchDone(bdone),
`ifdef PATH_SUMSQ_EN
        .oTotalSq(totsq),
`endif
        .oOverrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NC*AW-1:0] junk();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[NC*AW-1:0];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start_batch();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // iDone for one cycle, then the sums on iAcc in the following cycle.
    task automatic pulse(input logic [NC-1:0] mask, input logic [NC*AW-1:0] vals);
        done = mask;
        acc  = junk();
        tick();
        done = '0;
        acc  = vals;
        tick();
        acc  = junk();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_sum"}, psum, 0);
        chk({tag, "_core"}, pcore, 0);
        chk({tag, "_total"}, total, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_bdone"}, bdone, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    // Handshake log and hold-while-stalled check, sampled mid-cycle.
    typedef struct packed {logic [3:0] core; logic [AW-1:0] sum;} word_t;
    word_t      hs_q[$];
    logic       prev_stall = 1'b0;
    logic       prev_clr = 1'b1;
    logic [3:0] prev_core;
    logic [AW-1:0] prev_sum;

    always @(negedge clk) begin
        if (prev_stall && !prev_clr) begin
            chk("hold_valid", valid, 1);
            chk("hold_sum", psum, prev_sum);
            chk("hold_core", pcore, prev_core);
        end
        prev_stall = valid && ready;
        prev_stall = valid && !ready;
        prev_sum   = psum;
        prev_core  = pcore;
        prev_clr   = rst || start;
        if (valid && ready) hs_q.push_back(word_t'({pcore, psum}));
    end

    typedef struct {int core; logic [AW-1:0] val; logic [TW-1:0] exp_total;} vec_t;
    vec_t tbl[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC*AW-1:0] vals;
        word_t            w;
        logic [AW-1:0]    expv [NC];
        bit               outst [NC];
        int               issued, accepted, cyc, c;
        logic [TW-1:0]    exp_tot;
        logic [NC-1:0]    prev_mask, m;

        tbl[0] = '{2, 27'h0001234, 37'h1234};
        tbl[1] = '{0, 27'h0000000, 37'h0};
        tbl[2] = '{3, 27'h7FFFFFF, 37'h7FFFFFF};
        tbl[3] = '{1, 27'h5A5A5A5, 37'h5A5A5A5};
        tbl[4] = '{2, 27'h0000123, 37'h123};

        rst = 1'b0; start = 1'b0; ready = 1'b0; done = '0; acc = '0;
        do_reset();
        chk_all_zero("reset");

        // Single-core capture latency and accounting
        for (int i = 0; i < 5; i++) begin
            start_batch();
            ready = 1'b0;
            vals = '0;
            vals[tbl[i].core*AW +: AW] = tbl[i].val;
            pulse(NC'(1 << tbl[i].core), vals);
            chk("lat_early", valid, 0);
            tick();
            chk("lat_valid", valid, 1);
            chk("tbl_sum", psum, tbl[i].val);
            chk("tbl_core", pcore, tbl[i].core);
            ready = 1'b1;
            tick();
            ready = 1'b0;
            chk("tbl_total", total, tbl[i].exp_total);
            chk("tbl_count", count, 1);
            chk("tbl_drop", valid, 0);
        end

        // All cores at once: round-robin order, back-to-back
        start_batch();
        ready = 1'b1;
        pulse(4'hF, {27'd4, 27'd3, 27'd2, 27'd1});
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("rr_valid", valid, 1);
            chk("rr_core", pcore, i);
            chk("rr_sum", psum, i + 1);
            tick();
        end
        chk("rr_drop", valid, 0);
        chk("rr_total", total, 10);
        chk("rr_count", count, 4);
        chk("rr_bdone", bdone, 1);

        // Stall hold and overrun
        start_batch();
        ready = 1'b0;
        vals = '0; vals[1*AW +: AW] = 27'h55;
        pulse(4'h2, vals);
        tick();
        chk("st_valid", valid, 1);
        vals[1*AW +: AW] = 27'h66;
        pulse(4'h2, vals);
        chk("st_no_overrun", overrun, 0);
        vals[1*AW +: AW] = 27'h77;
        pulse(4'h2, vals);
        chk("st_overrun", overrun, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("st_sum", psum, 27'h55);
            chk("st_core", pcore, 1);
        end
        ready = 1'b1;
        tick();
        chk("st_second", psum, 27'h66);
        tick();
        chk("st_drop", valid, 0);
        chk("st_total", total, 27'hBB);
        chk("st_count", count, 2);
        tick();
        tick();
        chk("st_no_third", valid, 0);

        // Batch limit: six results, only four emitted; restart clears
        do_reset();
        start_batch();
        hs_q.delete();
        ready = 1'b1;
        pulse(4'hF, {27'd40, 27'd30, 27'd20, 27'd10});
        pulse(4'h3, {27'd0, 27'd0, 27'd60, 27'd50});
        for (int i = 0; i < 10; i++) tick();
        chk("lim_hs", hs_q.size(), 4);
        for (int i = 0; i < 4 && i < hs_q.size(); i++) begin
            chk("lim_core", hs_q[i].core, i);
            chk("lim_sum", hs_q[i].sum, 10 * (i + 1));
        end
        chk("lim_total", total, 100);
        chk("lim_count", count, 4);
        chk("lim_bdone", bdone, 1);
        chk("lim_overrun", overrun, 0);
        chk("lim_valid", valid, 0);
        start_batch();
        chk("rs_count", count, 0);
        chk("rs_total", total, 0);
        chk("rs_bdone", bdone, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("rs_discard", valid, 0);
        ready = 1'b0;

        // Pulses in IDLE are ignored; reset mid-drain
        do_reset();
        pulse(4'hF, junk());
        pulse(4'hF, junk());
        for (int i = 0; i < 4; i++) tick();
        chk("idle_valid", valid, 0);
        chk("idle_overrun", overrun, 0);
        start_batch();
        ready = 1'b1;
        pulse(4'hF, {27'd8, 27'd7, 27'd6, 27'd5});
        tick();
        tick();
        chk("mid_count", count, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ready = 1'b0;
        chk_all_zero("mid_rst");

`ifdef PATH_SUMSQ_EN
        start_batch();
        ready = 1'b1;
        pulse(4'h3, {27'd0, 27'd0, 27'd5, 27'd3});
        tick();
        tick();
        tick();
        chk("sq_total", total, 8);
        chk("sq_lag", totsq, 0);
        tick();
        tick();
        chk("sq_final", totsq, 34);
        ready = 1'b0;
`endif

        // Randomized batches against a per-core expected-value model
        do_reset();
        for (int b = 0; b < 30; b++) begin
            start_batch();
            hs_q.delete();
            issued = 0; accepted = 0; cyc = 0; exp_tot = '0; prev_mask = '0;
            for (int k = 0; k < int'(NC); k++) begin
                outst[k] = 1'b0;
                expv[k]  = '0;
            end
            while (accepted < 4 && cyc < 300) begin
                acc = junk();
                for (int k = 0; k < int'(NC); k++)
                    if (prev_mask[k]) acc[k*AW +: AW] = expv[k];
                m = '0;
                for (int k = 0; k < int'(NC); k++) begin
                    if (issued < 4 && !outst[k] && $urandom_range(0, 3) == 0) begin
                        m[k]     = 1'b1;
                        outst[k] = 1'b1;
                        expv[k]  = 27'($urandom());
                        exp_tot  = exp_tot + TW'(expv[k]);
                        issued++;
                    end
                end
                done      = m;
                prev_mask = m;
                ready     = ($urandom_range(0, 3) != 0);
                tick();
                cyc++;
                while (hs_q.size() > 0) begin
                    w = hs_q.pop_front();
                    c = int'(w.core);
                    if (c < int'(NC) && outst[c]) begin
                        chk("rnd_sum", w.sum, expv[c]);
                        outst[c] = 1'b0;
                    end else begin
                        chk("rnd_core_known", w.core, 4'hF);
                    end
                    accepted++;
                end
            end
            done  = '0;
            ready = 1'b0;
            chk("rnd_accepted", accepted, 4);
            chk("rnd_bdone", bdone, 1);
            chk("rnd_count", count, 4);
            chk("rnd_total", total, exp_tot);
            chk("rnd_overrun", overrun, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
